sr_fifo_uart_tx: RTL and testbench



---
 rtl/sr_fifo_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_sr_fifo_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_fifo_uart_tx.sv
// Purpose: pops 32-bit words from a show-ahead FIFO and sends each one as 8N1 UART bytes, LSB byte first.
// Latency: tx falls and fifo_pop pulses one edge after the IDLE decision; a word lasts (DATA_WIDTH/8)*10*CLK_DIV cycles.
// Backpressure: no pop while busy, or while the FIFO is empty or enable is low; at least one idle cycle between words.
//
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_rst          synchronous reset, active-high
//   i_enable       1 = new words may be started (sampled only in IDLE)
//   i_fifo_empty   FIFO empty flag
//   i_fifo_data    FIFO head word (show-ahead), valid when i_fifo_empty = 0
//   o_fifo_pop     one-cycle pop strobe to the FIFO
//   o_tx           serial line, idles high
//   o_busy         high while any frame of a word is in progress
//   o_word_count   count of fully transmitted words (wraps)
module sr_fifo_uart_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_pop,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_word_count
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [2:0]            r_bit;
    logic [BYTE_W-1:0]     r_byte;
    logic [DATA_WIDTH-1:0] r_shift_word;
    logic                  r_tx;
    logic                  r_fifo_pop;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_word_count;

    state_t                w_state_nxt;
    logic [BAUD_W-1:0]     w_baud_nxt;
    logic [2:0]            w_bit_nxt;
    logic [BYTE_W-1:0]     w_byte_nxt;
    logic [DATA_WIDTH-1:0] w_shift_word_nxt;
    logic                  w_tx_nxt;
    logic                  w_fifo_pop_nxt;
    logic                  w_busy_nxt;
    logic [CNT_WIDTH-1:0]  w_word_count_nxt;
    logic                  w_baud_done;

    assign w_baud_done = (r_baud == BAUD_LAST);

    // Every output is a flop; the next-state logic also computes the next
    // line level so tx changes on the same edge as the state.
    always_comb begin
        w_state_nxt      = r_state;
        w_baud_nxt       = w_baud_done ? '0 : r_baud + 1'b1;
        w_bit_nxt        = r_bit;
        w_byte_nxt       = r_byte;
        w_shift_word_nxt = r_shift_word;
        w_tx_nxt         = r_tx;
        w_fifo_pop_nxt   = 1'b0;
        w_busy_nxt       = r_busy;
        w_word_count_nxt = r_word_count;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (i_enable && !i_fifo_empty) begin
                    w_fifo_pop_nxt   = 1'b1;
                    w_shift_word_nxt = i_fifo_data;
                    w_byte_nxt       = '0;
                    w_state_nxt      = S_START;
                    w_tx_nxt         = 1'b0;
                    w_busy_nxt       = 1'b1;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift_word[0];
                end
            end
            S_DATA: begin
                // The word shifts right one bit per data bit, so after eight
                // shifts the next byte already sits in the low bits.
                if (w_baud_done) begin
                    w_shift_word_nxt = r_shift_word >> 1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_tx_nxt  = r_shift_word[1];
                    end
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    if (r_byte != BYTE_LAST) begin
                        w_byte_nxt  = r_byte + 1'b1;
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt      = S_IDLE;
                        w_tx_nxt         = 1'b1;
                        w_busy_nxt       = 1'b0;
                        w_word_count_nxt = r_word_count + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit        <= 3'd0;
            r_byte       <= '0;
            r_shift_word <= '0;
            r_tx         <= 1'b1;
            r_fifo_pop   <= 1'b0;
            r_busy       <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_baud       <= w_baud_nxt;
            r_bit        <= w_bit_nxt;
            r_byte       <= w_byte_nxt;
            r_shift_word <= w_shift_word_nxt;
            r_tx         <= w_tx_nxt;
            r_fifo_pop   <= w_fifo_pop_nxt;
            r_busy       <= w_busy_nxt;
            r_word_count <= w_word_count_nxt;
        end
    end

    assign o_fifo_pop   = r_fifo_pop;
    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_sr_fifo_uart_tx.sv
// Purpose: self-checking bench for sr_fifo_uart_tx against a queue-based FIFO and a frame-level line model.
// Latency: expects pop and start bit one edge after an IDLE decision, NB*10*CD busy cycles per word.
// Backpressure: checks no pops while busy, empty or disabled, and the single idle cycle between words.
module tb_sr_fifo_uart_tx;

    localparam int DW       = 32;
    localparam int CD       = 4;
    localparam int CW       = 2;
    localparam int NB       = DW / 8;
    localparam int WORD_CYC = NB * 10 * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_pop;
    logic          tx;
    logic          busy;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    sr_fifo_uart_tx #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (CD),
        .CNT_WIDTH (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (en),
        .i_fifo_empty(fifo_empty),
        .i_fifo_data (fifo_data),
        .o_fifo_pop  (fifo_pop),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_word_count(word_count)
    );

    int            n_checks  = 0;
    int            n_pass    = 0;
    int            exp_count = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] popped_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Line level k cycles into a word: frame = start 0, 8 data bits LSB first, stop 1.
    function automatic logic exp_tx(input logic [DW-1:0] w, input int k);
        int idx;
        int b;
        int pos;
        idx = k / CD;
        b   = idx / 10;
        pos = idx % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return w[b*8 + pos - 1];
    endfunction

    task automatic drive_fifo();
        fifo_empty = (q.size() == 0);
        if (q.size() != 0) fifo_data = q[0];
        else fifo_data = DW'($urandom);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        q.push_back(w);
        drive_fifo();
    endtask

    // Advance to the next negedge; a visible pop removes the model FIFO head.
    task automatic step();
        @(negedge clk);
        if (fifo_pop === 1'b1) begin
            chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                popped_w = q[0];
                void'(q.pop_front());
            end
        end
        drive_fifo();
    endtask

    task automatic wait_pop(input string tag, input int max_cyc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (fifo_pop === 1'b1) begin
                got = 1'b1;
                break;
            end
            chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
            chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
        chk({tag, "_pop_seen"}, 32'(got), 32'd1);
    endtask

    // Called at the negedge where the pop is first visible (cycle 0 of the word).
    task automatic check_word(input string tag, input logic [DW-1:0] w,
                              input int drop_en_at, input int rst_at);
        for (int k = 0; k < WORD_CYC; k++) begin
            if (k > 0) step();
            chk({tag, "_tx"}, 32'(tx), 32'(exp_tx(w, k)));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_pop"}, 32'(fifo_pop), 32'(k == 0));
            if (k == drop_en_at) en = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                chk({tag, "_rst_tx"}, 32'(tx), 32'd1);
                chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
                chk({tag, "_rst_pop"}, 32'(fifo_pop), 32'd0);
                chk({tag, "_rst_count"}, 32'(word_count), 32'd0);
                rst       = 1'b0;
                exp_count = 0;
                return;
            end
        end
        step();
        exp_count = (exp_count + 1) % (1 << CW);
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_tx"}, 32'(tx), 32'd1);
        chk({tag, "_end_pop"}, 32'(fifo_pop), 32'd0);
        chk({tag, "_end_count"}, 32'(word_count), 32'(exp_count));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst       = 1'b0;
        exp_count = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[5];
        seq = '{1, 2, 3, 0, 1};
        rst = 1'b1;
        en  = 1'b0;
        drive_fifo();

        // Reset state
        do_reset();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pop", 32'(fifo_pop), 32'd0);
        chk("reset_count", 32'(word_count), 32'd0);

        // 1: single word 0xA5
        en = 1'b1;
        push_word(32'h0000_00A5);
        wait_pop("t1", 3);
        check_word("t1", popped_w, -1, -1);

        // 2: empty FIFO with enable high
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t2_pop", 32'(fifo_pop), 32'd0);
            chk("t2_tx", 32'(tx), 32'd1);
            chk("t2_busy", 32'(busy), 32'd0);
        end

        // 3: back-to-back words, exactly one idle cycle between them
        push_word(32'h1122_3344);
        push_word(32'hDEAD_BEEF);
        wait_pop("t3a", 3);
        chk("t3a_word", popped_w, 32'h1122_3344);
        check_word("t3a", popped_w, -1, -1);
        wait_pop("t3b_gap", 1);
        chk("t3b_word", popped_w, 32'hDEAD_BEEF);
        check_word("t3b", popped_w, -1, -1);

        // 4: enable dropped during byte 1 of the first of three words
        for (int i = 0; i < 3; i++) push_word(DW'($urandom));
        wait_pop("t4a", 3);
        check_word("t4a", popped_w, 50, -1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_hold_pop", 32'(fifo_pop), 32'd0);
            chk("t4_hold_busy", 32'(busy), 32'd0);
        end
        chk("t4_queue_kept", 32'(q.size()), 32'd2);
        en = 1'b1;
        wait_pop("t4b_resume", 1);
        check_word("t4b", popped_w, -1, -1);
        wait_pop("t4c", 1);
        check_word("t4c", popped_w, -1, -1);

        // 5: reset during DATA of byte 2, then a clean restart
        push_word(DW'($urandom));
        push_word(DW'($urandom));
        wait_pop("t5a", 3);
        check_word("t5a", popped_w, -1, 2 * 10 * CD + 5 * CD);
        wait_pop("t5b_restart", 1);
        check_word("t5b", popped_w, -1, -1);
        chk("t5_queue_empty", 32'(q.size()), 32'd0);

        // 6: counter wrap with a 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) push_word(DW'($urandom));
        for (int i = 0; i < 5; i++) begin
            wait_pop("t6", 3);
            check_word("t6", popped_w, -1, -1);
            chk("t6_seq", 32'(word_count), 32'(seq[i]));
        end

        // Random words with random disabled gaps between them
        for (int i = 0; i < 6; i++) push_word(DW'($urandom));
        while (q.size() != 0) begin
            int gap;
            gap = int'($urandom_range(0, 5));
            en  = 1'b0;
            for (int g = 0; g < gap; g++) begin
                step();
                chk("rnd_gap_pop", 32'(fifo_pop), 32'd0);
            end
            en = 1'b1;
            wait_pop("rnd", 3);
            check_word("rnd", popped_w, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
